stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised, handshaked successor to the combinational 32-way mux. It selects one of M valid/ready input streams of width N and forwards it through a single registered output stage. Selection is either a fixed channel index (mux mode) or fair round-robin arbitration. It sits between producer stages (for example, multiple requesters feeding a shared bus or ALU port) and a single consumer.

## Interface
Parameters:
- N, 32, data width per channel.
- M, 32, channel count, M ≥ 2 (need not be a power of two).
- SW, $clog2(M), select/channel-index width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  M*N  flattened channel data; channel i occupies bits [i*N +: N].
- in_valid  input  M  per-channel valid.
- in_ready  output  M  per-channel ready (combinational).
- s  input  SW  fixed channel index, used when mode=0.
- mode  input  1  0 = fixed select, 1 = round-robin.
- out_data  output  N  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_chan  output  SW  registered index of the channel that produced out_data.

## Operation
- Output stage: one register holding out_data, out_chan and out_valid.
- load = !out_valid || out_ready. The stage can accept a beat when empty or being drained in the same cycle.
- Grant (combinational), evaluated every cycle:
  - mode=0: candidate is channel s only. grant_valid = in_valid[s] && s < M. If s ≥ M, there is no grant.
  - mode=1: scan channels ptr, ptr+1, …, wrapping modulo M. The first with in_valid set is granted.
- in_ready[i] = load && grant_valid && (i == grant). At most one bit is set; all bits are 0 when load=0.
- On a clock edge with load=1:
  - If grant_valid: out_data ← in_data[grant], out_chan ← grant, out_valid ← 1.
  - Otherwise: out_valid ← 0. out_data and out_chan hold their values.
- Round-robin pointer ptr (SW bits):
  - Updates only on an accepted beat in mode=1: ptr ← (grant == M-1) ? 0 : grant+1.
  - Unchanged in mode=0, so switching back to mode=1 resumes fairness from the last round-robin grant.
- Mode or s changes take effect on the next grant evaluation; no in-flight beat is affected.
- No input beat is lost or duplicated. A beat transfers exactly when in_valid[i] && in_ready[i] at a rising edge.
- Producers must hold in_data and in_valid stable until accepted. The block does not re-check this.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready is therefore 0 for any channel only when there is no grant; with out_valid=0, load=1.
- Release of rst_n is synchronous to the next edge; the first grant is possible on the first edge after release.
- Latency: input accepted at edge k appears on out_data/out_valid after edge k (visible in cycle k+1).
- Throughput: one beat per cycle when out_ready is held high.
- Backpressure: out_valid=1 && out_ready=0 forces all in_ready=0. Output values hold stable until out_ready.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant_valid=1): the new beat replaces the old one in the same edge with no bubble.
- Wrap-around: after a grant to channel M-1, ptr=0.
- Reset asserted mid-stream discards the held beat immediately; out_valid drops without waiting for a clock.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 and out_ready=1 → out_valid=0, out_data=0, out_chan=0. Deassert rst_n in mode=1 → first beat accepted from channel 0.
- Fixed mode, M=32, N=32: mode=0, s=17, in_data ch17=0xDEADBEEF, all valid, out_ready=1 → only in_ready[17]=1; next cycle out_data=0xDEADBEEF, out_chan=17. Steady one beat per cycle.
- Round-robin fairness: mode=1, channels 3, 9 and 31 valid continuously, out_ready=1 → grant sequence 3, 9, 31, 3, 9, …; ptr wraps to 0 after 31.
- Backpressure: out_valid=1 holding 0x12345678, out_ready=0 for 5 cycles → in_ready all 0 and output stable. Raise out_ready → next beat loaded that edge with no bubble.
- Non-power-of-two M=5: mode=1, all valid → chan sequence 0, 1, 2, 3, 4, 0. Mode=0 with s=6 → no grant, out_valid drops to 0 after drain.
- Mid-stream reset: during continuous round-robin transfer, pulse rst_n low between edges → out_valid falls immediately. After release, the first grant comes from the lowest valid channel ≥ 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: M-way valid/ready stream mux with one registered output
// stage; channel chosen by fixed index or fair round-robin arbitration.
module stream_mux_rr #(
    parameter int N = 32,
    parameter int M = 32,
    localparam int SW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M*N-1:0] in_data,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    input  logic [SW-1:0]  s,
    input  logic           mode,
    output logic [N-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_chan
);

    logic          load;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;

    logic          rr_valid;
    logic          rr_hi_valid;
    logic [SW-1:0] rr_lo;
    logic [SW-1:0] rr_hi;
    logic [SW-1:0] rr_grant;

    logic          fx_valid;

    logic [SW-1:0] grant;
    logic          grant_valid;
    logic [N-1:0]  sel_data;
    logic          accept;

    assign load = !out_valid || out_ready;

    // Two-pass priority: lowest valid at or above ptr, else lowest overall.
    always_comb begin
        rr_valid    = 1'b0;
        rr_hi_valid = 1'b0;
        rr_lo       = '0;
        rr_hi       = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_valid = 1'b1;
                rr_lo    = SW'(i);
                if (ptr <= SW'(i)) begin
                    rr_hi_valid = 1'b1;
                    rr_hi       = SW'(i);
                end
            end
        end
    end

    assign rr_grant = rr_hi_valid ? rr_hi : rr_lo;

    // An out-of-range s matches no channel, so it never grants.
    always_comb begin
        fx_valid = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (s == SW'(i)) begin
                fx_valid = in_valid[i];
            end
        end
    end

    assign grant       = mode ? rr_grant : s;
    assign grant_valid = mode ? rr_valid : fx_valid;
    assign accept      = load && grant_valid;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < M; i++) begin
            if (grant == SW'(i)) begin
                sel_data = in_data[i*N +: N];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < M; i++) begin
            in_ready[i] = accept && (grant == SW'(i));
        end
    end

    assign ptr_next = (grant == SW'(M - 1)) ? '0 : grant + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= sel_data;
                out_chan <= grant;
            end
        end
    end

    // Pointer only advances on round-robin beats so fixed-mode traffic
    // does not disturb fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && mode) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed bench for stream_mux_rr, one 32x32 instance
// and one non-power-of-two 5-channel instance.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [32*32-1:0] a_data;
    logic [31:0]      a_valid;
    logic [31:0]      a_in_ready;
    logic [4:0]       a_s;
    logic             a_mode;
    logic [31:0]      a_out_data;
    logic             a_out_valid;
    logic             a_out_ready;
    logic [4:0]       a_out_chan;

    logic [5*8-1:0]   b_data;
    logic [4:0]       b_valid;
    logic [4:0]       b_in_ready;
    logic [2:0]       b_s;
    logic             b_mode;
    logic [7:0]       b_out_data;
    logic             b_out_valid;
    logic             b_out_ready;
    logic [2:0]       b_out_chan;

    int passed = 0;
    int total = 0;

    stream_mux_rr #(.N(32), .M(32)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_data),
        .in_valid  (a_valid),
        .in_ready  (a_in_ready),
        .s         (a_s),
        .mode      (a_mode),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_chan  (a_out_chan)
    );

    stream_mux_rr #(.N(8), .M(5)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_data),
        .in_valid  (b_valid),
        .in_ready  (b_in_ready),
        .s         (b_s),
        .mode      (b_mode),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_chan  (b_out_chan)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rr_seq[5] = '{3, 9, 31, 3, 9};

    initial begin
        for (int i = 0; i < 32; i++) a_data[i*32 +: 32] = 32'hA000_0000 | i;
        a_data[17*32 +: 32] = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) b_data[i*8 +: 8] = 8'h50 + 8'(i);
        a_valid = '1;
        a_s = '0;
        a_mode = 1'b1;
        a_out_ready = 1'b1;
        b_valid = '0;
        b_s = '0;
        b_mode = 1'b1;
        b_out_ready = 1'b1;

        // Reset held with traffic offered
        step();
        step();
        check("rst_valid", 64'(a_out_valid), 64'd0);
        check("rst_data", 64'(a_out_data), 64'd0);
        check("rst_chan", 64'(a_out_chan), 64'd0);

        rst_n = 1'b1;
        step();
        check("first_valid", 64'(a_out_valid), 64'd1);
        check("first_chan", 64'(a_out_chan), 64'd0);
        check("first_data", 64'(a_out_data), 64'hA000_0000);

        // Fixed select
        a_mode = 1'b0;
        a_s = 5'd17;
        #1;
        check("fx_ready", 64'(a_in_ready), 64'h0002_0000);
        step();
        check("fx_data", 64'(a_out_data), 64'hDEAD_BEEF);
        check("fx_chan", 64'(a_out_chan), 64'd17);
        step();
        check("fx_steady", 64'(a_out_valid), 64'd1);
        check("fx_chan2", 64'(a_out_chan), 64'd17);

        // Round-robin among 3, 9, 31 (ptr=1 from the first beat)
        a_mode = 1'b1;
        a_valid = (32'd1 << 3) | (32'd1 << 9) | (32'd1 << 31);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_chan", 64'(a_out_chan), 64'(rr_seq[k]));
            check("rr_data", 64'(a_out_data), 64'hA000_0000 | 64'(rr_seq[k]));
        end

        // Backpressure
        a_mode = 1'b0;
        a_s = 5'd5;
        a_valid = 32'd1 << 5;
        a_data[5*32 +: 32] = 32'h1234_5678;
        step();
        check("bp_load", 64'(a_out_data), 64'h1234_5678);
        a_out_ready = 1'b0;
        a_valid = '1;
        a_s = 5'd6;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_ready", 64'(a_in_ready), 64'd0);
            check("bp_hold", 64'(a_out_data), 64'h1234_5678);
            check("bp_valid", 64'(a_out_valid), 64'd1);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release", 64'(a_in_ready), 64'h0000_0040);
        step();
        check("bp_next_data", 64'(a_out_data), 64'hA000_0006);
        check("bp_next_chan", 64'(a_out_chan), 64'd6);

        // Round-robin resumes after last rr grant (9), then mid-stream reset
        a_mode = 1'b1;
        step();
        check("resume_chan", 64'(a_out_chan), 64'd10);
        step();
        check("resume_chan2", 64'(a_out_chan), 64'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(a_out_valid), 64'd0);
        rst_n = 1'b1;
        a_valid = ~32'd3;
        step();
        check("post_rst_chan", 64'(a_out_chan), 64'd2);
        check("post_rst_valid", 64'(a_out_valid), 64'd1);

        // Five-channel instance
        b_valid = '1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("m5_chan", 64'(b_out_chan), 64'(k % 5));
            check("m5_data", 64'(b_out_data), 64'h50 + 64'(k % 5));
        end
        b_mode = 1'b0;
        b_s = 3'd6;
        #1;
        check("m5_oor_ready", 64'(b_in_ready), 64'd0);
        step();
        check("m5_oor_valid", 64'(b_out_valid), 64'd0);
        check("m5_oor_chan", 64'(b_out_chan), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
